// File: rtl/axi_crossbar_pkg.sv
// Shared widths and types for the AXI crossbar.
// Channel payload widths, response codes, slave index type.
package axi_crossbar_pkg;
  localparam int AWCH_W = 49;
  localparam int WCH_W  = 43;
  localparam int BCH_W  = 8;
  localparam int ARCH_W = 49;
  localparam int RCH_W  = 41;

  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int SLV_IDX_W = 4;
  typedef logic [SLV_IDX_W-1:0] slv_idx_t;
endpackage

// File: rtl/axi_crossbar_route_fifo.sv
// W routing FIFO: holds the target slave of each accepted AW.
// Ports: clk, srst, push/din, pop/dout, full, empty.
module axi_crossbar_route_fifo
  import axi_crossbar_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     srst,
  input  logic     push,
  input  slv_idx_t din,
  input  logic     pop,
  output slv_idx_t dout,
  output logic     full,
  output logic     empty
);
  slv_idx_t      mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign dout    = mem[rp[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/round_arbiter.sv
// Round-robin arbiter; a grant stays locked until done.
// Ports: clk, srst, req, done in; gnt index, gnt_vld out.
module round_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [IW-1:0] gnt,
  output logic          gnt_vld
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] lock_idx;
  logic          locked;
  logic          any;
  logic          lock_req;
  logic [N-1:0]  high;

  // Requests at or above ptr win first, then wrap.
  always_comb begin
    high = '0;
    for (int k = 0; k < N; k++)
      high[k] = req[k] & (IW'(k) >= ptr);
    pick = ptr;
    any  = |req;
    for (int k = N-1; k >= 0; k--)
      if (req[k]) pick = IW'(k);
    if (|high)
      for (int k = N-1; k >= 0; k--)
        if (high[k]) pick = IW'(k);
  end

  always_comb begin
    lock_req = 1'b0;
    for (int k = 0; k < N; k++)
      if (lock_idx == IW'(k)) lock_req = req[k];
  end

  assign gnt     = locked ? lock_idx : pick;
  assign gnt_vld = locked ? lock_req : any;

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr      <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (gnt_vld & done) begin
      locked <= 1'b0;
      ptr    <= (gnt == IW'(N-1)) ? '0 : gnt + 1'b1;
    end else if (gnt_vld & ~locked) begin
      locked   <= 1'b1;
      lock_idx <= pick;
    end
  end
endmodule

// File: rtl/axi_crossbar_mst_switch.sv
// Master-side crossbar switch: one master to SLV_NB slaves.
// Ports: i_* master AW/W/B/AR/R, o_* per-slave channels.
module axi_crossbar_mst_switch
  import axi_crossbar_pkg::*;
#(
  parameter int SLV_NB = 3,
  parameter int AXI_ADDR_W = 32,
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR =
    {32'h2000, 32'h1000, 32'h0000},
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR =
    {32'h2FFF, 32'h1FFF, 32'h0FFF},
  parameter int MAX_OSTD = 8,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    i_awvalid,
  output logic                    i_awready,
  input  logic [AWCH_W-1:0]       i_awch,
  input  logic                    i_wvalid,
  output logic                    i_wready,
  input  logic                    i_wlast,
  input  logic [WCH_W-1:0]        i_wch,
  output logic                    i_bvalid,
  input  logic                    i_bready,
  output logic [BCH_W-1:0]        i_bch,
  input  logic                    i_arvalid,
  output logic                    i_arready,
  input  logic [ARCH_W-1:0]       i_arch,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  output logic                    i_rlast,
  output logic [RCH_W-1:0]        i_rch,
  output logic [SLV_NB-1:0]       o_awvalid,
  input  logic [SLV_NB-1:0]       o_awready,
  output logic [AWCH_W-1:0]       o_awch,
  output logic [SLV_NB-1:0]       o_wvalid,
  input  logic [SLV_NB-1:0]       o_wready,
  output logic                    o_wlast,
  output logic [WCH_W-1:0]        o_wch,
  input  logic [SLV_NB-1:0]       o_bvalid,
  output logic [SLV_NB-1:0]       o_bready,
  input  logic [SLV_NB*BCH_W-1:0] o_bch,
  output logic [SLV_NB-1:0]       o_arvalid,
  input  logic [SLV_NB-1:0]       o_arready,
  output logic [ARCH_W-1:0]       o_arch,
  input  logic [SLV_NB-1:0]       o_rvalid,
  output logic [SLV_NB-1:0]       o_rready,
  input  logic [SLV_NB-1:0]       o_rlast,
  input  logic [SLV_NB*RCH_W-1:0] o_rch
);
  localparam int CNT_W = $clog2(MAX_OSTD + 1);
  localparam int GW = (SLV_NB > 1) ? $clog2(SLV_NB) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OSTD);

  // Lowest matching slave wins; misses go to the last slave.
  function automatic slv_idx_t decode(
    input logic [AXI_ADDR_W-1:0] a
  );
    slv_idx_t s;
    s = slv_idx_t'(SLV_NB - 1);
    for (int k = SLV_NB-1; k >= 0; k--)
      if (a >= SLV_START_ADDR[k*AXI_ADDR_W +: AXI_ADDR_W] &&
          a <= SLV_END_ADDR[k*AXI_ADDR_W +: AXI_ADDR_W])
        s = slv_idx_t'(k);
    return s;
  endfunction

  slv_idx_t        aw_sel;
  slv_idx_t        ar_sel;
  slv_idx_t        wr_tgt;
  slv_idx_t        rd_tgt;
  slv_idx_t        w_head;
  slv_idx_t        b_sel;
  slv_idx_t        r_sel;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic            aw_stall;
  logic            ar_stall;
  logic            aw_rdy;
  logic            ar_rdy;
  logic            w_rdy;
  logic            aw_hs;
  logic            ar_hs;
  logic            w_hs;
  logic            b_hs;
  logic            r_hs;
  logic            r_done;
  logic            wf_full;
  logic            wf_empty;
  logic [GW-1:0]   b_gnt;
  logic [GW-1:0]   r_gnt;
  logic            b_vld;
  logic            r_vld;
  logic            r_last_sel;

  assign aw_sel = decode(i_awch[AXI_ADDR_W-1:0]);
  assign ar_sel = decode(i_arch[AXI_ADDR_W-1:0]);

  // A different target must wait for all older requests to drain.
  assign aw_stall = (wr_cnt == CNT_MAX) | wf_full |
                    ((wr_cnt != '0) & (aw_sel != wr_tgt));
  assign ar_stall = (rd_cnt == CNT_MAX) |
                    ((rd_cnt != '0) & (ar_sel != rd_tgt));

  assign o_awch  = i_awch;
  assign o_arch  = i_arch;
  assign o_wch   = i_wch;
  assign o_wlast = i_wlast;

  always_comb begin
    o_awvalid = '0;
    o_arvalid = '0;
    aw_rdy    = 1'b0;
    ar_rdy    = 1'b0;
    for (int k = 0; k < SLV_NB; k++) begin
      if (aw_sel == slv_idx_t'(k)) begin
        aw_rdy       = o_awready[k];
        o_awvalid[k] = i_awvalid & ~aw_stall;
      end
      if (ar_sel == slv_idx_t'(k)) begin
        ar_rdy       = o_arready[k];
        o_arvalid[k] = i_arvalid & ~ar_stall;
      end
    end
  end

  assign i_awready = aw_rdy & ~aw_stall;
  assign i_arready = ar_rdy & ~ar_stall;
  assign aw_hs     = i_awvalid & i_awready;
  assign ar_hs     = i_arvalid & i_arready;

  axi_crossbar_route_fifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (aclk),
    .srst  (srst),
    .push  (aw_hs),
    .din   (aw_sel),
    .pop   (w_hs & i_wlast),
    .dout  (w_head),
    .full  (wf_full),
    .empty (wf_empty)
  );

  always_comb begin
    o_wvalid = '0;
    w_rdy    = 1'b0;
    for (int k = 0; k < SLV_NB; k++)
      if (w_head == slv_idx_t'(k)) begin
        w_rdy       = o_wready[k];
        o_wvalid[k] = i_wvalid & ~wf_empty;
      end
  end

  assign i_wready = w_rdy & ~wf_empty;
  assign w_hs     = i_wvalid & i_wready;

  round_arbiter #(.N(SLV_NB)) u_b_arb (
    .clk     (aclk),
    .srst    (srst),
    .req     (o_bvalid),
    .done    (b_hs),
    .gnt     (b_gnt),
    .gnt_vld (b_vld)
  );

  round_arbiter #(.N(SLV_NB)) u_r_arb (
    .clk     (aclk),
    .srst    (srst),
    .req     (o_rvalid),
    .done    (r_done),
    .gnt     (r_gnt),
    .gnt_vld (r_vld)
  );

  assign b_sel = slv_idx_t'(b_gnt);
  assign r_sel = slv_idx_t'(r_gnt);

  always_comb begin
    i_bch      = '0;
    i_rch      = '0;
    o_bready   = '0;
    o_rready   = '0;
    r_last_sel = 1'b0;
    for (int k = 0; k < SLV_NB; k++) begin
      if (b_sel == slv_idx_t'(k)) begin
        i_bch       = o_bch[k*BCH_W +: BCH_W];
        o_bready[k] = i_bready & b_vld;
      end
      if (r_sel == slv_idx_t'(k)) begin
        i_rch       = o_rch[k*RCH_W +: RCH_W];
        r_last_sel  = o_rlast[k];
        o_rready[k] = i_rready & r_vld;
      end
    end
  end

  assign i_bvalid = b_vld;
  assign i_rvalid = r_vld;
  assign i_rlast  = r_vld & r_last_sel;
  assign b_hs     = b_vld & i_bready;
  assign r_hs     = r_vld & i_rready;
  assign r_done   = r_hs & i_rlast;

  // A response with nothing outstanding holds the counter at zero.
  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_tgt <= '0;
      rd_tgt <= '0;
    end else begin
      if (aw_hs) wr_tgt <= aw_sel;
      if (ar_hs) rd_tgt <= ar_sel;
      unique case (1'b1)
        aw_hs & ~b_hs:
          wr_cnt <= wr_cnt + 1'b1;
        b_hs & ~aw_hs & (wr_cnt != '0):
          wr_cnt <= wr_cnt - 1'b1;
        default: ;
      endcase
      unique case (1'b1)
        ar_hs & ~r_done:
          rd_cnt <= rd_cnt + 1'b1;
        r_done & ~ar_hs & (rd_cnt != '0):
          rd_cnt <= rd_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_crossbar_mst_switch.sv
// Scoreboard bench for the master-side crossbar switch.
// Drives master and slave sides, checks routing and ordering.
module tb_axi_crossbar_mst_switch;
  import axi_crossbar_pkg::*;

  localparam int N = 3;

  logic aclk = 1'b0;
  logic srst;
  logic i_awvalid, i_awready;
  logic [AWCH_W-1:0] i_awch;
  logic i_wvalid, i_wready, i_wlast;
  logic [WCH_W-1:0] i_wch;
  logic i_bvalid, i_bready;
  logic [BCH_W-1:0] i_bch;
  logic i_arvalid, i_arready;
  logic [ARCH_W-1:0] i_arch;
  logic i_rvalid, i_rready, i_rlast;
  logic [RCH_W-1:0] i_rch;
  logic [N-1:0] o_awvalid, o_awready;
  logic [AWCH_W-1:0] o_awch;
  logic [N-1:0] o_wvalid, o_wready;
  logic o_wlast;
  logic [WCH_W-1:0] o_wch;
  logic [N-1:0] o_bvalid, o_bready;
  logic [N*BCH_W-1:0] o_bch;
  logic [N-1:0] o_arvalid, o_arready;
  logic [ARCH_W-1:0] o_arch;
  logic [N-1:0] o_rvalid, o_rready, o_rlast;
  logic [N*RCH_W-1:0] o_rch;

  always #5 aclk = ~aclk;

  axi_crossbar_mst_switch dut (
    .aclk(aclk), .srst(srst),
    .i_awvalid(i_awvalid), .i_awready(i_awready),
    .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready),
    .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready),
    .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready),
    .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready),
    .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready),
    .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready),
    .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready),
    .o_rlast(o_rlast), .o_rch(o_rch)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always @(posedge aclk) begin
    if (!srst) begin
      assert (!(i_bvalid && i_bready && dut.wr_cnt == 0))
        else $error("slave error: B with no write outstanding");
      assert (!(i_rvalid && i_rready && i_rlast &&
                dut.rd_cnt == 0))
        else $error("slave error: R last with no read outstanding");
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    i_awvalid = 0; i_awch = '0;
    i_wvalid = 0; i_wlast = 0; i_wch = '0;
    i_bready = 0;
    i_arvalid = 0; i_arch = '0;
    i_rready = 0;
    o_awready = '0; o_wready = '0;
    o_bvalid = '0; o_bch = '0;
    o_arready = '0;
    o_rvalid = '0; o_rlast = '0; o_rch = '0;
  endtask

  task automatic do_reset();
    idle();
    srst = 1;
    step();
    step();
    srst = 0;
  endtask

  task automatic aw_send(input logic [31:0] a,
                         input logic [2:0] rdy,
                         input logic [2:0] oh,
                         input logic acc);
    i_awvalid = 1;
    i_awch = AWCH_W'(a);
    o_awready = rdy;
    #1;
    check("aw_vld", 64'(o_awvalid), 64'(oh));
    check("aw_rdy", 64'(i_awready), 64'(acc));
    step();
    i_awvalid = 0;
  endtask

  task automatic ar_send(input logic [31:0] a,
                         input logic [2:0] rdy,
                         input logic [2:0] oh,
                         input logic acc);
    i_arvalid = 1;
    i_arch = ARCH_W'(a);
    o_arready = rdy;
    #1;
    check("ar_vld", 64'(o_arvalid), 64'(oh));
    check("ar_rdy", 64'(i_arready), 64'(acc));
    step();
    i_arvalid = 0;
  endtask

  task automatic w_beat(input logic [2:0] oh,
                        input logic [WCH_W-1:0] d,
                        input logic last);
    logic [63:0] e;
    i_wvalid = 1;
    i_wch = d;
    i_wlast = last;
    exp_q.push_back({17'd0, oh, last, d});
    #1;
    e = exp_q.pop_front();
    check("w_beat", {17'd0, o_wvalid, o_wlast, o_wch}, e);
    check("w_rdy", 64'(i_wready), 64'd1);
    step();
    i_wvalid = 0;
    i_wlast = 0;
  endtask

  task automatic b_resp(input int k, input logic [7:0] d);
    logic [2:0] oh;
    logic [63:0] e;
    oh = 3'(1 << k);
    o_bvalid = oh;
    o_bch[k*BCH_W +: BCH_W] = d;
    i_bready = 1;
    exp_q.push_back({53'd0, oh, d});
    #1;
    check("b_vld", 64'(i_bvalid), 64'd1);
    e = exp_q.pop_front();
    check("b_pay", {53'd0, o_bready, i_bch}, e);
    step();
    o_bvalid = '0;
    i_bready = 0;
  endtask

  function automatic logic [RCH_W-1:0] rdat(input int k,
                                            input int b);
    return RCH_W'(32'h100 * k + b + 7);
  endfunction

  initial begin
    int beat [2];
    int lasts;
    logic [2:0] rr;
    logic lastbeat;
    logic [63:0] e;

    do_reset();
    i_wvalid = 1; o_wready = '1;
    i_bready = 1; i_rready = 1;
    #1;
    check("rst_awvalid", 64'(o_awvalid), 0);
    check("rst_wvalid", 64'(o_wvalid), 0);
    check("rst_wready", 64'(i_wready), 0);
    check("rst_bvalid", 64'(i_bvalid), 0);
    check("rst_rvalid", 64'(i_rvalid), 0);
    check("rst_wr_cnt", 64'(dut.wr_cnt), 0);
    check("rst_rd_cnt", 64'(dut.rd_cnt), 0);
    idle();
    step();

    // AW to slave1 with W offered in the same cycle
    o_wready = 3'b010;
    i_wvalid = 1; i_wch = WCH_W'(43'h77);
    i_awvalid = 1; i_awch = AWCH_W'(32'h1004);
    o_awready = 3'b010;
    #1;
    check("aw1_vld", 64'(o_awvalid), 64'(3'b010));
    check("aw1_rdy", 64'(i_awready), 1);
    check("w_nobypass_v", 64'(o_wvalid), 0);
    check("w_nobypass_r", 64'(i_wready), 0);
    step();
    i_awvalid = 0;
    for (int b = 0; b < 4; b++)
      w_beat(3'b010, WCH_W'(43'h1000 + b), b == 3);
    i_wvalid = 1;
    #1;
    check("wf_empty_v", 64'(o_wvalid), 0);
    check("wf_empty_r", 64'(i_wready), 0);
    check("wr_cnt1", 64'(dut.wr_cnt), 1);
    i_wvalid = 0;
    b_resp(1, 8'h5a);
    check("wr_cnt0", 64'(dut.wr_cnt), 0);

    // Different-target AW waits for the older B
    aw_send(32'h0000, 3'b111, 3'b001, 1);
    i_awvalid = 1; i_awch = AWCH_W'(32'h2000);
    #1;
    check("stall_v", 64'(o_awvalid), 0);
    check("stall_r", 64'(i_awready), 0);
    step();
    o_bvalid = 3'b001; o_bch[7:0] = 8'h11; i_bready = 1;
    exp_q.push_back({53'd0, 3'b001, 8'h11});
    #1;
    check("stall_r2", 64'(i_awready), 0);
    e = exp_q.pop_front();
    check("b0_pay", {53'd0, o_bready, i_bch}, e);
    step();
    o_bvalid = '0; i_bready = 0;
    #1;
    check("unstall_v", 64'(o_awvalid), 64'(3'b100));
    check("unstall_r", 64'(i_awready), 1);
    step();
    i_awvalid = 0;
    o_wready = 3'b111;
    w_beat(3'b001, WCH_W'(43'h2a), 1);
    w_beat(3'b100, WCH_W'(43'h2b), 1);
    b_resp(2, 8'h33);
    check("wr_cnt_t2", 64'(dut.wr_cnt), 0);

    // Miss goes to default slave; outstanding limit
    aw_send(32'h9000, 3'b000, 3'b100, 0);
    for (int i = 0; i < 8; i++) begin
      aw_send(32'h0100 + 32'(i * 4), 3'b111, 3'b001, 1);
      w_beat(3'b001, WCH_W'(i), 1);
    end
    check("wr_cnt8", 64'(dut.wr_cnt), 8);
    aw_send(32'h0200, 3'b111, 3'b000, 0);
    for (int i = 0; i < 8; i++)
      b_resp(0, 8'(i + 1));
    check("wr_cnt_drain", 64'(dut.wr_cnt), 0);

    // W FIFO full blocks the fifth AW
    do_reset();
    for (int i = 0; i < 4; i++)
      aw_send(32'h0000 + 32'(i), 3'b111, 3'b001, 1);
    aw_send(32'h0010, 3'b111, 3'b000, 0);
    check("wr_cnt4", 64'(dut.wr_cnt), 4);

    // R bursts from two slaves stay unbroken
    do_reset();
    ar_send(32'h0010, 3'b111, 3'b001, 1);
    ar_send(32'h0020, 3'b111, 3'b001, 1);
    check("rd_cnt2", 64'(dut.rd_cnt), 2);
    ar_send(32'h1000, 3'b111, 3'b000, 0);
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({22'd0, b == 3, rdat(k, b)});
    beat[0] = 0; beat[1] = 0; lasts = 0;
    i_rready = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (beat[0] >= 4 && beat[1] >= 4) break;
      for (int k = 0; k < 2; k++) begin
        o_rvalid[k] = beat[k] < 4;
        o_rlast[k] = beat[k] == 3;
        o_rch[k*RCH_W +: RCH_W] = rdat(k, beat[k]);
      end
      #1;
      if (i_rvalid) begin
        e = exp_q.pop_front();
        check("r_beat", {22'd0, i_rlast, i_rch}, e);
        check("r_rdy", 64'(o_rready),
              beat[0] < 4 ? 64'd1 : 64'd2);
      end
      rr = o_rready;
      lastbeat = i_rvalid & i_rlast;
      step();
      for (int k = 0; k < 2; k++)
        if (rr[k]) beat[k]++;
      if (lastbeat) begin
        lasts++;
        check("rd_cnt_dec", 64'(dut.rd_cnt), 64'(2 - lasts));
      end
    end
    o_rvalid = '0; o_rlast = '0;
    check("r_done", 64'(exp_q.size()), 0);

    // Reset in the middle of a W burst
    do_reset();
    aw_send(32'h1000, 3'b111, 3'b010, 1);
    o_wready = 3'b111;
    w_beat(3'b010, WCH_W'(43'h51), 0);
    w_beat(3'b010, WCH_W'(43'h52), 0);
    i_wvalid = 1;
    srst = 1;
    step();
    check("mid_wvalid", 64'(o_wvalid), 0);
    check("mid_wready", 64'(i_wready), 0);
    check("mid_awvalid", 64'(o_awvalid), 0);
    check("mid_bvalid", 64'(i_bvalid), 0);
    check("mid_rvalid", 64'(i_rvalid), 0);
    check("mid_wr_cnt", 64'(dut.wr_cnt), 0);
    check("mid_rd_cnt", 64'(dut.rd_cnt), 0);
    srst = 0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_crossbar_mst_switch.md
Name:
axi_crossbar_mst_switch

Overview:
Master-side switch of the AXI crossbar: connects one master port to SLV_NB slave switches.
- AW/AR are routed by address decode.
- W beats follow AW order through a routing FIFO.
- B/R responses from the slaves are arbitrated back to the single master; R bursts are locked until rlast.
- Per-direction outstanding tracking stalls a new request to a different slave while older requests are still pending, so responses stay in order.

Parameters:
SLV_NB, 3, number of slave ports
AXI_ADDR_W, 32, address width; address is bits [AXI_ADDR_W-1:0] of the AW/AR channel vectors
SLV_START_ADDR, {32'h2000,32'h1000,32'h0000}, packed start addresses, slave k at slice k
SLV_END_ADDR, {32'h2FFF,32'h1FFF,32'h0FFF}, packed inclusive end addresses
MAX_OSTD, 8, maximum outstanding transactions per direction
WFIFO_DEPTH, 4, depth of the W routing FIFO (power of two)

Ports:
aclk  in  1  clock
srst  in  1  synchronous active-high reset
i_awvalid  in  1  master AW valid
i_awready  out  1  master AW ready
i_awch  in  AWCH_W  master AW payload
i_wvalid  in  1  master W valid
i_wready  out  1  master W ready
i_wlast  in  1  master W last
i_wch  in  WCH_W  master W payload
i_bvalid  out  1  B valid to master
i_bready  in  1  master B ready
i_bch  out  BCH_W  B payload to master
i_arvalid  in  1  master AR valid
i_arready  out  1  master AR ready
i_arch  in  ARCH_W  master AR payload
i_rvalid  out  1  R valid to master
i_rready  in  1  master R ready
i_rlast  out  1  R last to master
i_rch  out  RCH_W  R payload to master
o_awvalid  out  SLV_NB  per-slave AW valid
o_awready  in  SLV_NB  per-slave AW ready
o_awch  out  AWCH_W  AW payload, broadcast to all slaves
o_wvalid  out  SLV_NB  per-slave W valid
o_wready  in  SLV_NB  per-slave W ready
o_wlast  out  1  W last, broadcast
o_wch  out  WCH_W  W payload, broadcast
o_bvalid  in  SLV_NB  per-slave B valid
o_bready  out  SLV_NB  per-slave B ready
o_bch  in  SLV_NB*BCH_W  concatenated B payloads
o_arvalid  out  SLV_NB  per-slave AR valid
o_arready  in  SLV_NB  per-slave AR ready
o_arch  out  ARCH_W  AR payload, broadcast
o_rvalid  in  SLV_NB  per-slave R valid
o_rready  out  SLV_NB  per-slave R ready
o_rlast  in  SLV_NB  per-slave R last
o_rch  in  SLV_NB*RCH_W  concatenated R payloads

Behaviour:
- Reset: srst sampled on aclk. All valid/ready outputs 0; wr_cnt and rd_cnt 0; W FIFO empty; R lock cleared; arbiter pointers at slave 0. srst mid-burst discards all tracking state; no partial-burst recovery.
- Decode (combinational, 0 latency): slave k hits if START_k <= addr <= END_k. Lowest k wins on overlap. No hit routes to slave SLV_NB-1 (default slave).
- AW forwarding: o_awvalid[sel] = i_awvalid & !aw_stall; i_awready = o_awready[sel] & !aw_stall.
- aw_stall = (wr_cnt==MAX_OSTD) | wfifo_full | (wr_cnt!=0 & sel!=wr_tgt).
- On AW handshake: wr_cnt+1, wr_tgt<=sel, push sel into W FIFO.
- W: FIFO empty forces o_wvalid=0 and i_wready=0. Otherwise o_wvalid[head] = i_wvalid and i_wready = o_wready[head]. Pop on W handshake with i_wlast.
- No bypass: the first W beat is forwarded no earlier than the cycle after its AW handshake. W arriving before AW simply waits.
- B: round-robin over o_bvalid; the grant holds until its handshake completes. i_bvalid = o_bvalid[g], i_bch = o_bch slice g, o_bready[g] = i_bready. wr_cnt-1 on handshake.
- Same-cycle AW and B handshakes leave wr_cnt unchanged.
- AR: same rules as AW, using rd_cnt and rd_tgt; no FIFO.
- R: round-robin grant, locked from first beat until the rlast handshake; i_rlast = o_rlast[g]. rd_cnt-1 on the last-beat handshake; same-cycle AR accept plus last-beat handshake leaves rd_cnt unchanged.
- Counters are clog2(MAX_OSTD+1) bits and never wrap. A response arriving with cnt==0 is a slave error: the counter holds at 0 and the bench flags it with an assertion.

Decomposition:
- Package axi_crossbar_pkg: AWCH_W=49, WCH_W=43, BCH_W=8, ARCH_W=49, RCH_W=41, AXI_RESP_DECERR, and a slave-index typedef.
- Reuse the existing round_arbiter for the B and R arbiters.
- One new sub-module: axi_crossbar_route_fifo (W routing FIFO with full/empty flags).

Test Plan:
- AW addr 0x1004 with a 4-beat W burst; slave1 ready -> o_awvalid=3'b010; four W beats on slave1 only, the first one cycle after the AW handshake; FIFO empty after wlast.
- AW to 0x0000, then AW to 0x2000 before B returns -> second AW stalled (i_awready=0) until slave0 B handshake, then accepted by slave2.
- Addr 0x9000 -> routed to slave2; 9 AWs to slave0 with B withheld -> 9th stalls at wr_cnt=8.
- o_rvalid from slave0 and slave1 together, 4-beat bursts -> slave0 burst completes uninterrupted, then slave1; rd_cnt decrements on each rlast.
- 5 AWs with no W and WFIFO_DEPTH=4 -> 5th AW stalled on wfifo_full.
- srst asserted mid W burst -> next cycle all outputs 0, counters 0, FIFO empty.
